// File: rtl/fr_normalizer.sv
// Two-stage leading-one normalizer for the FP MAC datapath.
// Define FR_NORM_DENORM_EN to produce denormals instead of flushing on underflow.
module fr_normalizer #(
   parameter int WIDTH = 24,
   parameter int EXP_W = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [WIDTH-1:0] in_mant,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic [WIDTH-1:0] out_mant,
   output logic             out_zero,
   output logic             out_uflow
);

   localparam int SH_W = $clog2(WIDTH);

   logic             s1_valid;
   logic             s1_sign;
   logic             s1_zero;
   logic [EXP_W-1:0] s1_exp;
   logic [WIDTH-1:0] s1_mant;
   logic [SH_W-1:0]  s1_shift;

   logic             s1_load;
   logic             s2_load;
   logic [SH_W-1:0]  lz_shift;

   logic [EXP_W:0]   exp_ext;
   logic [EXP_W:0]   sh_ext;
   logic             uflow;
   logic [WIDTH-1:0] nx_mant;
   logic [EXP_W-1:0] nx_exp;
   logic             nx_zero;
   logic             nx_uflow;
`ifdef FR_NORM_DENORM_EN
   logic [EXP_W:0]   lim_ext;
`endif

   assign s2_load  = !out_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;

   // Ascending scan: the highest set bit writes last and wins.
   always_comb begin
      lz_shift = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (in_mant[i]) lz_shift = SH_W'(WIDTH - 1 - i);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_zero  <= 1'b0;
         s1_exp   <= '0;
         s1_mant  <= '0;
         s1_shift <= '0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign  <= in_sign;
            s1_zero  <= (in_mant == '0);
            s1_exp   <= in_exp;
            s1_mant  <= in_mant;
            s1_shift <= lz_shift;
         end
      end
   end

   // Underflow when the adjusted exponent would fall below 1.
   always_comb begin
      exp_ext  = {1'b0, s1_exp};
      sh_ext   = (EXP_W + 1)'(s1_shift);
      uflow    = !s1_zero && (exp_ext <= sh_ext);
      nx_mant  = s1_mant << s1_shift;
      nx_exp   = s1_exp - EXP_W'(s1_shift);
      nx_zero  = s1_zero;
      nx_uflow = uflow;
`ifdef FR_NORM_DENORM_EN
      lim_ext  = '0;
`endif
      if (s1_zero) begin
         nx_mant = '0;
         nx_exp  = '0;
      end else if (uflow) begin
`ifdef FR_NORM_DENORM_EN
         lim_ext = (exp_ext == '0) ? '0 : exp_ext - (EXP_W + 1)'(1);
         nx_mant = s1_mant << lim_ext[SH_W-1:0];
         nx_exp  = '0;
`else
         nx_mant = '0;
         nx_exp  = '0;
         nx_zero = 1'b1;
`endif
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_valid <= 1'b0;
         out_sign  <= 1'b0;
         out_exp   <= '0;
         out_mant  <= '0;
         out_zero  <= 1'b0;
         out_uflow <= 1'b0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_sign  <= s1_sign;
            out_exp   <= nx_exp;
            out_mant  <= nx_mant;
            out_zero  <= nx_zero;
            out_uflow <= nx_uflow;
         end
      end
   end

endmodule
